// File: rtl/variable_pkg.sv
// variable_pkg: shared sprite sizes, colour key and XGA raster timing for the draw stages.
package variable_pkg;
  localparam int SPRITE_W_CAT = 64;
  localparam int SPRITE_H_CAT = 64;
  localparam int SPRITE_W_DOG = 64;
  localparam int SPRITE_H_DOG = 64;
  localparam logic [11:0] COLOR_KEY = 12'hF0F;
  localparam int HOR_TOTAL       = 1344;
  localparam int HOR_BLANK_START = 1024;
  localparam int HOR_SYNC_START  = 1048;
  localparam int HOR_SYNC_STOP   = 1184;
  localparam int VER_TOTAL       = 806;
  localparam int VER_BLANK_START = 768;
  localparam int VER_SYNC_START  = 771;
  localparam int VER_SYNC_STOP   = 777;
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing and colour bundle passed between draw stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// vga_delay: registers a whole VGA bundle N times, zeroed by reset.
module vga_delay
  import variable_pkg::*;
#(
  parameter int N = 1
) (
  input  logic clk60MHz,
  input  logic rst,
  vga_if.in    in,
  vga_if.out   out
);
  vga_t stage_q [N];
  vga_t stage_d [N];
  always_comb begin
    stage_d[0] = '{in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
    for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk60MHz)
    if (rst) stage_q <= '{default: '0};
    else stage_q <= stage_d;
  assign out.hcount = stage_q[N-1].hcount;
  assign out.vcount = stage_q[N-1].vcount;
  assign out.hsync  = stage_q[N-1].hsync;
  assign out.vsync  = stage_q[N-1].vsync;
  assign out.hblnk  = stage_q[N-1].hblnk;
  assign out.vblnk  = stage_q[N-1].vblnk;
  assign out.rgb    = stage_q[N-1].rgb;
endmodule

// File: rtl/draw_sprite.sv
// draw_sprite: overlays one colour-keyed sprite from an external 1-clock ROM onto the VGA stream.
module draw_sprite
  import variable_pkg::*;
#(
  parameter int          SPRITE_W    = SPRITE_W_CAT,
  parameter int          SPRITE_H    = SPRITE_H_CAT,
  parameter logic [11:0] TRANSPARENT = COLOR_KEY,
  parameter int          ADDR_W      = 12
) (
  input  logic              clk60MHz,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  vga_if.in                 in,
  vga_if.out                out
);
  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);
  logic [11:0] x_l_q, x_l_d, y_l_q, y_l_d;
  logic        en_l_q, en_l_d, inside_q, inside_d;
  logic [12:0] hx, vy, x_end, y_end;
  logic [XB-1:0] dx;
  logic [YB-1:0] dy;
  vga_t out_q, out_d;
  vga_if d1 ();
  vga_delay #(.N(1)) u_stage1 (
    .clk60MHz(clk60MHz),
    .rst     (rst),
    .in      (in),
    .out     (d1)
  );
  // 13-bit compares keep a sprite near 4095 from wrapping back onto the left/top edge
  always_comb begin
    x_l_d    = (in.hcount == '0 && in.vcount == '0) ? xpos   : x_l_q;
    y_l_d    = (in.hcount == '0 && in.vcount == '0) ? ypos   : y_l_q;
    en_l_d   = (in.hcount == '0 && in.vcount == '0) ? enable : en_l_q;
    hx       = {2'b0, in.hcount};
    vy       = {2'b0, in.vcount};
    x_end    = {1'b0, x_l_q} + 13'(SPRITE_W);
    y_end    = {1'b0, y_l_q} + 13'(SPRITE_H);
    dx       = in.hcount[XB-1:0] - x_l_q[XB-1:0];
    dy       = in.vcount[YB-1:0] - y_l_q[YB-1:0];
    inside_d = en_l_q & ~in.hblnk & ~in.vblnk & (hx >= {1'b0, x_l_q}) & (hx < x_end)
             & (vy >= {1'b0, y_l_q}) & (vy < y_end);
    rom_addr = inside_d ? ADDR_W'({dy, dx}) : '0;
    out_d    = '{d1.hcount, d1.vcount, d1.hsync, d1.vsync, d1.hblnk, d1.vblnk,
                 (inside_q && rom_data != TRANSPARENT) ? rom_data : d1.rgb};
  end
  always_ff @(posedge clk60MHz)
    if (rst) begin
      x_l_q    <= '0;
      y_l_q    <= '0;
      en_l_q   <= 1'b0;
      inside_q <= 1'b0;
      out_q    <= '0;
    end else begin
      x_l_q    <= x_l_d;
      y_l_q    <= y_l_d;
      en_l_q   <= en_l_d;
      inside_q <= inside_d;
      out_q    <= out_d;
    end
  assign out.hcount = out_q.hcount;
  assign out.vcount = out_q.vcount;
  assign out.hsync  = out_q.hsync;
  assign out.vsync  = out_q.vsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.vblnk  = out_q.vblnk;
  assign out.rgb    = out_q.rgb;
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed and random pixel beats checked against a coordinate-level sprite model.
module tb_draw_sprite;
  import variable_pkg::*;
  localparam int SW = 64;
  localparam int SH = 64;
  typedef struct packed {
    logic [25:0] tim;
    logic [11:0] rgb;
  } exp_t;
  logic        clk60MHz = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        enable = 1'b0;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] last_addr;
  logic [11:0] rand_rom [4096];
  int          checks = 0;
  int          errors = 0;
  int          rom_mode = 0;
  int          mx = 0;
  int          my = 0;
  bit          men = 1'b0;
  exp_t        q[$];
  int          hl[15] = '{0, 1, 2, 1022, 1023, 1024, 1025, 1047, 1048, 1049, 1183, 1184, 1185, 1342, 1343};
  int          rows[6] = '{49, 50, 51, 113, 114, 200};
  int          clip_rows[4] = '{739, 740, 767, 768};
  vga_if vin ();
  vga_if vout ();
  draw_sprite #(.SPRITE_W(SW), .SPRITE_H(SH), .TRANSPARENT(COLOR_KEY), .ADDR_W(12)) dut (
    .clk60MHz(clk60MHz),
    .rst     (rst),
    .xpos    (xpos),
    .ypos    (ypos),
    .enable  (enable),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .in      (vin),
    .out     (vout)
  );
  always #8 clk60MHz = ~clk60MHz;
  function automatic logic [11:0] rom_fn(int a);
    if (rom_mode == 0) return 12'h0F0;
    if (rom_mode == 1) return (a % 2 == 0) ? 12'hF0F : 12'hF00;
    return rand_rom[a % 4096];
  endfunction
  always @(posedge clk60MHz) rom_data <= rom_fn(int'(rom_addr));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(int h, int v, logic [11:0] rgb);
    bit hs, vs, hb, vb, ins;
    int addr;
    logic [11:0] pix;
    exp_t e;
    hb = h >= HOR_BLANK_START;
    vb = v >= VER_BLANK_START;
    hs = h >= HOR_SYNC_START && h < HOR_SYNC_STOP;
    vs = v >= VER_SYNC_START && v < VER_SYNC_STOP;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    #1;
    ins  = men && !hb && !vb && h >= mx && h < mx + SW && v >= my && v < my + SH;
    addr = ins ? (v - my) * SW + (h - mx) : 0;
    last_addr = rom_addr;
    check("rom_addr", 64'(rom_addr), 64'(addr));
    pix   = rom_fn(addr);
    e.tim = {11'(h), 11'(v), hs, vs, hb, vb};
    e.rgb = (ins && pix != COLOR_KEY) ? pix : rgb;
    if (rst) begin
      foreach (q[i]) q[i] = '0;
      q.push_back('0);
      mx = 0;
      my = 0;
      men = 1'b0;
    end else begin
      q.push_back(e);
      if (h == 0 && v == 0) begin
        mx = int'(xpos);
        my = int'(ypos);
        men = enable;
      end
    end
    @(posedge clk60MHz);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("out_timing", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 64'(e.tim));
      check("out_rgb", 64'(vout.rgb), 64'(e.rgb));
    end
  endtask
  initial begin
    int h, v;
    foreach (rand_rom[i]) rand_rom[i] = (i % 7 == 3) ? COLOR_KEY : 12'($urandom);
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
    vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;
    @(posedge clk60MHz);
    #1;
    for (int i = 0; i < 5; i++) beat(i + 3, 10, 12'h00F);
    check("reset_out", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb}), 64'(0));
    rst = 1'b0;
    xpos = 12'd100; ypos = 12'd50; enable = 1'b1; rom_mode = 0;
    beat(0, 0, 12'h00F);
    foreach (rows[r])
      for (int x = 90; x <= 175; x++) begin
        beat(x, rows[r], 12'h00F);
        if (x == 100 && rows[r] == 50) check("addr_first", 64'(last_addr), 64'h000);
        if (x == 163 && rows[r] == 113) check("addr_last", 64'(last_addr), 64'hFFF);
      end
    rom_mode = 1;
    for (int x = 95; x <= 170; x++) beat(x, 60, 12'h00F);
    rom_mode = 0;
    beat(0, 0, 12'h00F);
    for (int x = 90; x <= 380; x++) beat(x, 199, 12'h00F);
    xpos = 12'd300;
    for (int y = 200; y <= 201; y++)
      for (int x = 90; x <= 380; x++) beat(x, y, 12'h00F);
    beat(0, 0, 12'h00F);
    for (int x = 90; x <= 380; x++) beat(x, 60, 12'h00F);
    xpos = 12'd1000; ypos = 12'd740;
    beat(0, 0, 12'h00F);
    foreach (clip_rows[r])
      for (int x = 990; x <= 1060; x++) beat(x, clip_rows[r], 12'h00F);
    for (int x = 0; x <= 45; x++) beat(x, 741, 12'h00F);
    xpos = 12'd1024; ypos = 12'd100;
    beat(0, 0, 12'h00F);
    for (int x = 1010; x <= 1100; x++) beat(x, 120, 12'h00F);
    xpos = 12'd500; ypos = 12'd768;
    beat(0, 0, 12'h00F);
    for (int x = 490; x <= 580; x++) beat(x, 770, 12'h00F);
    enable = 1'b0; rom_mode = 2;
    for (int y = 0; y < VER_TOTAL; y++)
      foreach (hl[j]) beat(hl[j], y, 12'($urandom));
    for (int f = 0; f < 15; f++) begin
      xpos = 12'($urandom_range(0, 1100));
      ypos = 12'($urandom_range(0, 800));
      enable = ($urandom % 4) != 0;
      beat(0, 0, 12'($urandom));
      for (int k = 0; k < 400; k++) begin
        if ($urandom % 50 == 0) xpos = 12'($urandom_range(0, 1100));
        if (f == 7 && k == 200) rst = 1'b1;
        if (f == 7 && k == 203) rst = 1'b0;
        if (k % 2 == 1) begin
          h = int'($urandom_range(0, HOR_TOTAL - 1));
          v = int'($urandom_range(0, VER_TOTAL - 1));
        end else begin
          h = mx + int'($urandom_range(0, SW + 8)) - 4;
          v = my + int'($urandom_range(0, SH + 8)) - 4;
        end
        h = h < 0 ? 0 : (h > HOR_TOTAL - 1 ? HOR_TOTAL - 1 : h);
        v = v < 0 ? 0 : (v > VER_TOTAL - 1 ? VER_TOTAL - 1 : v);
        beat(h, v, 12'($urandom));
      end
    end
    beat(5, 5, 12'h000);
    beat(6, 5, 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
